// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx arbiter and its round-robin picker.
package uart_arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SEND  = 2'd2,
    WAIT  = 2'd3
  } arb_state_t;

  localparam int DEFAULT_MAX_BURST = 4;
  localparam int MAX_REQ = 8;

  // OR-reduce the set bit positions; exact for a one-hot (or zero) input.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request after rr_ptr (wrapping),
// with optional absolute priority for request 0.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  input  logic               prio_en,
  output logic               found,
  output logic [IW-1:0]      winner
);

  logic [NUM_REQ-1:0] grant_oh;
  logic [MAX_REQ-1:0] grant_wide;
  logic [IW-1:0]      idx;

  always_comb begin
    grant_oh = '0;
    idx      = '0;
    if (prio_en && req[0]) begin
      grant_oh[0] = 1'b1;
    end else begin
      // rr_ptr itself is visited last, so the previous owner only re-wins alone
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
        if (req[idx] && (grant_oh == '0)) grant_oh[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    grant_wide = '0;
    grant_wide[NUM_REQ-1:0] = grant_oh;
  end

  assign found  = |req;
  assign winner = IW'(onehot_to_idx(grant_wide));

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx among NUM_REQ requesters.
// Optional build macro UART_TX_ARB_PRIO_EN makes requester 0 urgent at arbitration points.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [DATA_WIDTH-1:0]          tx_data,
  input  logic                           tx_done,
  output logic                           grant_vld,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]      BURST_MAX = BW'(MAX_BURST);
  localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);
`ifdef UART_TX_ARB_PRIO_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  arb_state_t            state_reg, state_next;
  logic [IW-1:0]         rr_ptr_reg, rr_ptr_next;
  logic [BW-1:0]         burst_cnt_reg, burst_cnt_next;
  logic                  last_reg, last_next;
  logic [NUM_REQ-1:0]    req_ready_next;
  logic                  tx_start_next;
  logic [DATA_WIDTH-1:0] tx_data_next;
  logic                  grant_vld_next;
  logic [IW-1:0]         grant_id_next;

  logic [NUM_REQ-1:0] owner_oh, others, pick_req;
  logic               pick_found, prio_win, release_now;
  logic [IW-1:0]      pick_id;

  assign owner_oh = ONE << grant_id;
  assign others   = req_valid & ~owner_oh;
  assign prio_win = PRIO_EN && req_valid[0];

  // On rotation the current owner steps aside unless nobody else is waiting
  always_comb begin
    pick_req = req_valid;
    if (state_reg == WAIT) begin
      pick_req    = (|others) ? others : req_valid;
      pick_req[0] = pick_req[0] | prio_win;
    end
  end

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req     (pick_req),
    .rr_ptr  (rr_ptr_reg),
    .prio_en (PRIO_EN),
    .found   (pick_found),
    .winner  (pick_id)
  );

  assign release_now = last_reg || (burst_cnt_reg == BURST_MAX) || !req_valid[grant_id];

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    last_next      = last_reg;
    req_ready_next = '0;
    tx_start_next  = 1'b0;
    tx_data_next   = tx_data;
    grant_vld_next = grant_vld;
    grant_id_next  = grant_id;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_vld_next = 1'b1;
          grant_id_next  = pick_id;
          if (!prio_win) rr_ptr_next = pick_id;
          req_ready_next = ONE << pick_id;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        tx_data_next   = data_arr[grant_id];
        last_next      = req_last[grant_id];
        burst_cnt_next = burst_cnt_reg + 1'b1;
        tx_start_next  = 1'b1;
        state_next     = SEND;
      end
      SEND: state_next = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (release_now) begin
            burst_cnt_next = '0;
            if (pick_found) begin
              grant_id_next  = pick_id;
              if (!prio_win) rr_ptr_next = pick_id;
              req_ready_next = ONE << pick_id;
              state_next     = GRANT;
            end else begin
              grant_vld_next = 1'b0;
              state_next     = IDLE;
            end
          end else begin
            req_ready_next = owner_oh;
            state_next     = GRANT;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= IW'(NUM_REQ - 1);
      burst_cnt_reg <= '0;
      last_reg      <= 1'b0;
      req_ready     <= '0;
      tx_start      <= 1'b0;
      tx_data       <= '0;
      grant_vld     <= 1'b0;
      grant_id      <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      burst_cnt_reg <= burst_cnt_next;
      last_reg      <= last_next;
      req_ready     <= req_ready_next;
      tx_start      <= tx_start_next;
      tx_data       <= tx_data_next;
      grant_vld     <= grant_vld_next;
      grant_id      <= grant_id_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues plus a uart_tx stand-in
// that answers each tx_start with a tx_done pulse a few cycles later.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        arstn;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        tx_start, tx_done, grant_vld;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;

  uart_tx_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_BURST  (4)
  ) dut (
    .clk       (clk),
    .arstn     (arstn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          timer    = 0;
  bit          auto_en  = 1'b0;
  logic [3:0]  hold     = 4'b0;
  logic [7:0]  qd [4][$];
  logic        ql [4][$];
  logic [1:0]  log_id [$];
  logic [7:0]  log_data [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (qd[i].size() > 0) begin
        req_valid[i]       = !hold[i];
        req_data[i*8 +: 8] = qd[i][0];
        req_last[i]        = ql[i][0];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: sample at negedge, update stimulus 1 time unit after posedge
  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    acc = req_ready & req_valid;
    if (tx_start === 1'b1) begin
      log_id.push_back(grant_id);
      log_data.push_back(tx_data);
      $display("[%0t] tx id=%0d data=%02h", $time, grant_id, tx_data);
      if (auto_en) timer = 3;
    end
    @(posedge clk);
    #1;
    if (auto_en) begin
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && qd[i].size() > 0) begin
          qd[i].delete(0);
          ql[i].delete(0);
        end
      end
      tx_done = 1'b0;
      if (timer > 0) begin
        timer--;
        if (timer == 0) tx_done = 1'b1;
      end
      drive();
    end
  endtask

  task automatic do_reset();
    auto_en = 1'b0;
    timer   = 0;
    hold    = 4'b0;
    for (int i = 0; i < 4; i++) begin
      qd[i].delete();
      ql[i].delete();
    end
    log_id.delete();
    log_data.delete();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_done   = 1'b0;
    arstn     = 1'b0;
    step();
    step();
    arstn = 1'b1;
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int b = 0;
    while (log_id.size() < n && b < budget) begin
      step();
      b++;
    end
    check(tag, log_id.size(), n);
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    qd[r].push_back(d);
    ql[r].push_back(l);
  endtask

  // Verify logged ids against a table; data is {id, per-id byte index}
  task automatic check_rr_seq(input string tag, input int exp_ids [8], input int n);
    int cnt [4] = '{0, 0, 0, 0};
    for (int j = 0; j < n; j++) begin
      check({tag, "_id"}, log_id[j], exp_ids[j]);
      check({tag, "_data"}, log_data[j], (exp_ids[j] << 4) | cnt[exp_ids[j]]);
      cnt[exp_ids[j]]++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp2 [8];
    int exp5 [8];
    int exp3_id [7]   = '{1, 1, 1, 1, 3, 1, 1};
    int exp3_data [7] = '{'h61, 'h62, 'h63, 'h64, 'hC3, 'h65, 'h66};
    int exp4_id [4]   = '{0, 2, 0, 0};
    int exp4_data [4] = '{'hA0, 'hB2, 'hA1, 'hA2};
`ifdef UART_TX_ARB_PRIO_EN
    exp2 = '{0, 0, 1, 2, 3, 1, 2, 3};
    exp5 = '{0, 0, 0, 3, 3, 3, 0, 0};
`else
    exp2 = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp5 = '{0, 3, 0, 3, 0, 3, 0, 0};
`endif

    // Single byte, latency and reset state
    do_reset();
    check("rst_ready", req_ready, 4'b0000);
    check("rst_start", tx_start, 1'b0);
    check("rst_data", tx_data, 8'h00);
    check("rst_gvld", grant_vld, 1'b0);
    check("rst_gid", grant_id, 2'd0);
    req_valid = 4'b0100;
    req_data  = 32'h00A5_0000;
    req_last  = 4'b0100;
    step();
    check("t1_ready", req_ready, 4'b0100);
    check("t1_gvld", grant_vld, 1'b1);
    check("t1_gid", grant_id, 2'd2);
    check("t1_start_early", tx_start, 1'b0);
    step();
    check("t1_start", tx_start, 1'b1);
    check("t1_data", tx_data, 8'hA5);
    check("t1_ready_pulse", req_ready, 4'b0000);
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    step();
    check("t1_start_pulse", tx_start, 1'b0);
    step();
    step();
    check("t1_data_hold", tx_data, 8'hA5);
    check("t1_gvld_wait", grant_vld, 1'b1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("t1_release", grant_vld, 1'b0);
    check("t1_release_ready", req_ready, 4'b0000);

    // Round-robin fairness, every byte a packet
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) push(i, 8'((i << 4) | k), 1'b1);
    auto_en = 1'b1;
    wait_log("t2_count", 8, 300);
    check_rr_seq("t2", exp2, 8);

    // Burst cap forces rotation mid-packet
    do_reset();
    for (int k = 1; k <= 6; k++) push(1, 8'(8'h60 + k), k == 6);
    push(3, 8'hC3, 1'b1);
    auto_en = 1'b1;
    wait_log("t3_count", 7, 300);
    for (int j = 0; j < 7; j++) begin
      check("t3_id", log_id[j], exp3_id[j]);
      check("t3_data", log_data[j], exp3_data[j]);
    end

    // Owner stalls mid-packet and loses the grant
    do_reset();
    push(0, 8'hA0, 1'b0);
    push(0, 8'hA1, 1'b0);
    push(0, 8'hA2, 1'b1);
    push(2, 8'hB2, 1'b1);
    auto_en = 1'b1;
    wait_log("t4_first", 1, 100);
    hold[0] = 1'b1;
    wait_log("t4_second", 2, 100);
    hold[0] = 1'b0;
    wait_log("t4_count", 4, 200);
    for (int j = 0; j < 4; j++) begin
      check("t4_id", log_id[j], exp4_id[j]);
      check("t4_data", log_data[j], exp4_data[j]);
    end

    // Requesters 0 and 3 contend at every arbitration point
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push(0, 8'(k), 1'b1);
      push(3, 8'(8'h30 | k), 1'b1);
    end
    auto_en = 1'b1;
    wait_log("t5_count", 6, 300);
    check_rr_seq("t5", exp5, 6);

    // Reset while waiting on tx_done
    do_reset();
    push(1, 8'h5A, 1'b1);
    auto_en = 1'b1;
    wait_log("t6_send", 1, 100);
    auto_en   = 1'b0;
    timer     = 0;
    tx_done   = 1'b0;
    req_valid = '0;
    arstn     = 1'b0;
    step();
    arstn = 1'b1;
    check("t6_ready", req_ready, 4'b0000);
    check("t6_start", tx_start, 1'b0);
    check("t6_data", tx_data, 8'h00);
    check("t6_gvld", grant_vld, 1'b0);
    check("t6_gid", grant_id, 2'd0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("t6_spurious_ready", req_ready, 4'b0000);
      check("t6_spurious_start", tx_start, 1'b0);
      step();
    end
    check("t6_no_resend", log_id.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
